// File: rtl/seq_alu_if.sv
// Issue/writeback handshake bundle for seq_alu: operation request channel
// and tagged result channel, each with its own valid/ready pair.
interface seq_alu_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [TAG_W-1:0] tag_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [7:0]       status;
   logic [TAG_W-1:0] tag_out;
   logic             busy;

   modport master (
      output in_valid, op, a, b, tag_in, out_ready,
      input  in_ready, out_valid, result, status, tag_out, busy
   );

   modport slave (
      input  in_valid, op, a, b, tag_in, out_ready,
      output in_ready, out_valid, result, status, tag_out, busy
   );
endinterface

// File: rtl/seq_alu.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/add/shift ops, iterative
// shift-add multiply and restoring divide on magnitudes with sign fixup.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_alu_if.slave  bus
);
   localparam int SH_W = $clog2(WIDTH);
   localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);
   localparam logic [SH_W-1:0] CNT_ONE  = SH_W'(1);
   localparam logic [SH_W-1:0] CNT_ZERO = SH_W'(0);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
   localparam logic [3:0] OP_ADDW = 4'd12;
   localparam logic [3:0] OP_ADDH = 4'd13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_r, state_s;

   logic             in_ready_s, accept_s, iter_s;
   logic [WIDTH-1:0] simple_res_s;
   logic [7:0]       simple_stat_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] diff_s;
   logic             big_shift_s, cy_s, neg_s, al_s, dz_s;

   logic [WIDTH-1:0] hi_r, lo_r, dvs_r;
   logic             neg_r, is_mul_r;
   logic [SH_W-1:0]  cnt_r;
   logic [WIDTH:0]   mul_sum_s, div_sh_s;
   logic [WIDTH-1:0] div_sub_s;
   logic             div_ge_s;
   logic [WIDTH-1:0] hi_s, lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0] iter_res_s;
   logic [7:0]       iter_stat_s;

   logic [WIDTH-1:0] result_r;
   logic [7:0]       status_r;
   logic [TAG_W-1:0] tag_r;
   logic             out_valid_r, busy_r;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      if (v[WIDTH-1]) begin
         mag = {WIDTH{1'b0}} - v;
      end else begin
         mag = v;
      end
   endfunction

   function automatic logic [7:0] pack_status(input logic [WIDTH-1:0] res,
      input logic ovf, input logic cy, input logic neg, input logic al,
      input logic dz);
      pack_status = {(res == {WIDTH{1'b0}}), ovf, cy, neg, al, dz, 2'b00};
   endfunction

   assign iter_s   = (bus.op == OP_MUL) | ((bus.op == OP_DIV) & (|bus.b));
   assign accept_s = bus.in_valid & in_ready_s;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_s = iter_s ? ST_BUSY : ST_DONE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (bus.out_ready && bus.in_valid) begin
               state_s = iter_s ? ST_BUSY : ST_DONE;
            end else if (bus.out_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Output logic: acceptance window, including handover while draining
   always_comb begin
      in_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: in_ready_s = 1'b1;
         ST_DONE: in_ready_s = bus.out_ready;
         default: in_ready_s = 1'b0;
      endcase
   end

   // Single-cycle result and flags computed from the offered operands
   always_comb begin
      sum_s        = {1'b0, bus.a} + {1'b0, bus.b};
      diff_s       = bus.a - bus.b;
      big_shift_s  = |bus.b[WIDTH-1:SH_W];
      simple_res_s = {WIDTH{1'b0}};
      cy_s         = 1'b0;
      neg_s        = 1'b0;
      al_s         = 1'b0;
      dz_s         = 1'b0;
      case (bus.op)
         OP_AND: simple_res_s = bus.a & bus.b;
         OP_OR:  simple_res_s = bus.a | bus.b;
         OP_XOR: simple_res_s = bus.a ^ bus.b;
         OP_NOR: simple_res_s = ~(bus.a | bus.b);
         OP_ADD: begin
            simple_res_s = sum_s[WIDTH-1:0];
            cy_s         = sum_s[WIDTH];
            neg_s        = sum_s[WIDTH-1];
         end
         OP_SUB: begin
            simple_res_s = diff_s;
            cy_s         = (bus.a < bus.b);
            neg_s        = diff_s[WIDTH-1];
         end
         OP_ADDW: begin
            simple_res_s = sum_s[WIDTH-1:0];
            al_s         = (sum_s[1:0] == 2'b00);
            neg_s        = sum_s[WIDTH-1];
         end
         OP_ADDH: begin
            simple_res_s = sum_s[WIDTH-1:0];
            al_s         = ~sum_s[0];
            neg_s        = sum_s[WIDTH-1];
         end
         OP_SLT: simple_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLL: simple_res_s = big_shift_s ? {WIDTH{1'b0}} : (bus.a << bus.b[SH_W-1:0]);
         OP_SRL: simple_res_s = big_shift_s ? {WIDTH{1'b0}} : (bus.a >> bus.b[SH_W-1:0]);
         OP_DIV: dz_s = ~(|bus.b);
         default: simple_res_s = {WIDTH{1'b0}};
      endcase
      simple_stat_s = pack_status(simple_res_s, 1'b0, cy_s, neg_s, al_s, dz_s);
   end

   // One multiply/divide step; on the last step the fixed-up result is also formed
   always_comb begin
      mul_sum_s = {1'b0, hi_r} + {1'b0, (lo_r[0] ? dvs_r : {WIDTH{1'b0}})};
      div_sh_s  = {hi_r, lo_r[WIDTH-1]};
      div_ge_s  = (div_sh_s >= {1'b0, dvs_r});
      div_sub_s = div_sh_s[WIDTH-1:0] - dvs_r;
      if (is_mul_r) begin
         hi_s = mul_sum_s[WIDTH:1];
         lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end else begin
         hi_s = div_ge_s ? div_sub_s : div_sh_s[WIDTH-1:0];
         lo_s = {lo_r[WIDTH-2:0], div_ge_s};
      end
      prod_s     = {hi_s, lo_s};
      prod_fix_s = neg_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
      if (is_mul_r) begin
         iter_res_s  = prod_fix_s[WIDTH-1:0];
         iter_stat_s = pack_status(iter_res_s,
            (prod_fix_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix_s[WIDTH-1]}}),
            1'b0, iter_res_s[WIDTH-1], 1'b0, 1'b0);
      end else begin
         iter_res_s  = neg_r ? ({WIDTH{1'b0}} - lo_s) : lo_s;
         iter_stat_s = pack_status(iter_res_s, 1'b0, 1'b0, iter_res_s[WIDTH-1], 1'b0, 1'b0);
      end
   end

   // Datapath registers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         dvs_r       <= {WIDTH{1'b0}};
         neg_r       <= 1'b0;
         is_mul_r    <= 1'b0;
         cnt_r       <= CNT_ZERO;
         result_r    <= {WIDTH{1'b0}};
         status_r    <= 8'h00;
         tag_r       <= {TAG_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         out_valid_r <= (state_s == ST_DONE);
         busy_r      <= (state_s == ST_BUSY);
         if (accept_s) begin
            tag_r    <= bus.tag_in;
            is_mul_r <= (bus.op == OP_MUL);
            neg_r    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= mag(bus.a);
            dvs_r    <= mag(bus.b);
            cnt_r    <= CNT_LAST;
            if (!iter_s) begin
               result_r <= simple_res_s;
               status_r <= simple_stat_s;
            end
         end else if (state_r == ST_BUSY) begin
            hi_r  <= hi_s;
            lo_r  <= lo_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ZERO) begin
               result_r <= iter_res_s;
               status_r <= iter_stat_s;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.status    = status_r;
   assign bus.tag_out   = tag_r;
   assign bus.busy      = busy_r;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor of the combinational 32-bit ALU.
- Same 4-bit opcode set and 8-bit status layout, generalised to WIDTH bits.
- Multiply and divide are iterative shift-add / restoring units instead of single-cycle `*` and `/`.
- Sits between the decode/issue stage and writeback. A tag travels with each operation so the issuer can match results.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4 and a power of two.
- TAG_W, 4, width of the pass-through operation tag.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept the operation this cycle
- op  in  4  opcode: 0 AND, 1 OR, 10 XOR, 11 NOR, 2 ADD, 6 SUB, 5 MUL, 4 DIV, 12 ADD+word-align check, 13 ADD+half-align check, 7 SLT, 8 SLL, 9 SRL; others → NOP
- a  in  WIDTH  operand A, signed
- b  in  WIDTH  operand B, signed (shift amount for 8/9)
- tag_in  in  TAG_W  issuer tag
- out_valid  out  1  result/status/tag_out valid
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  result
- status  out  8  [7] zero, [6] mul overflow, [5] carry/borrow, [4] negative, [3] aligned, [2] div-by-zero, [1:0] always 0
- tag_out  out  TAG_W  tag of the completed op
- busy  out  1  high in BUSY state

Behaviour:
- FSM states and transitions:
  - IDLE: in_ready=1.
  - BUSY: iterating on MUL or DIV.
  - DONE: out_valid=1.
- Reset (rst_n=0 at a clock edge): state=IDLE, out_valid=0, busy=0, result=0, status=0, tag_out=0, internal counters cleared. Reset mid-BUSY or mid-DONE aborts the op; its result is never presented.
- Accept: in_valid & in_ready at edge T captures op, a, b and tag_in.
- Non-iterative ops, and DIV with b==0: go to DONE at T+1, so out_valid is high in cycle T+1.
- MUL and DIV with b≠0: go to BUSY with counter=WIDTH-1; one iteration per cycle. DONE, with out_valid, is reached in cycle T+WIDTH+1.
- DONE holds result/status/tag_out stable until out_ready=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A new op accepted while the old result drains gives back-to-back throughput of 1 op/cycle for simple ops. in_ready=0 in BUSY.
- in_valid is ignored whenever in_ready=0. No input is sampled during BUSY.
- Arithmetic rules:
  - ADD: {carry,result}=a+b unsigned, carry → [5].
  - SUB: result=a-b; [5]=1 iff unsigned a<b (borrow).
  - [4] = result[WIDTH-1] for ADD, SUB, MUL, DIV, 12 and 13; 0 for all other ops.
  - Ops 12 and 13: result=a+b. [3]=1 iff result[1:0]==0 (op 12) or result[0]==0 (op 13). [3]=0 for all other ops.
  - SLT: result=1 if signed a<b (true signed compare, correct on overflow), else 0.
  - SLL / SRL: logical shift by unsigned b. If b>=WIDTH, result=0.
  - MUL: signed, iterating on magnitudes with sign fixup; result = low WIDTH bits. [6]=1 iff the full 2·WIDTH product is not the sign extension of result.
  - DIV: signed quotient, truncated toward zero; remainder discarded. Restoring algorithm on magnitudes with sign fixup. Most-negative / -1 gives result=most-negative, [6]=0.
  - DIV with b==0: result=0, [2]=1, no iteration.
- [7] = (result==0) for every op, including NOP (NOP: result=0, [7]=1, other bits 0).
- Flags not listed for an op are 0. status[1:0] are always 0.
- An op accepted in the same cycle its predecessor drains follows the normal latency from that edge.

Test Plan:
- WIDTH=32. op=2, a=0xFFFFFFFF, b=1, out_ready=1 → cycle T+1: result=0, status=0xA0 ([7], [5]), tag_out=tag_in.
- op=5, a=-3, b=7 → out_valid exactly at T+33, result=-21 (0xFFFFFFEB), status=0x10. Then a=0x10000, b=0x10000 → result=0, status=0xC0.
- op=4, a=-7, b=2 → result=-3 at T+33, status=0x10. Then op=4, b=0 → result=0, status=0x84 at T+1.
- Reset: rst_n low at BUSY cycle 10 of a MUL → next cycle IDLE, out_valid=0, busy=0. Re-issue op=7, a=0x80000000, b=1 → result=1, status=0x00.
- Back-pressure: hold out_ready=0 for 5 cycles after op=12, a=6, b=2 → result=8, status=0x08 stable, in_ready=0. Raise out_ready with in_valid high (op=8, a=1, b=40) → handover in the same cycle; next cycle result=0, status=0x80.
- Streaming: 8 consecutive AND/OR/XOR/NOR ops with out_ready=1 → one result per cycle, in order, tags 0..7 preserved.
